// File: rtl/hpdmc_initseq_pkg.sv
// Shared constants, FSM state type and bypass-word helper for the hpdmc SDRAM
// power-up sequencer.
package hpdmc_initseq_pkg;

   localparam logic [31:0] CSR_SYSTEM = 32'h0000_0000;
   localparam logic [31:0] CSR_BYPASS = 32'h0000_0004;

   // Bypass command nibbles, {CS,WE,CAS,RAS}
   localparam logic [3:0] CMD_PRECHARGE = 4'hB;
   localparam logic [3:0] CMD_REFRESH   = 4'hD;
   localparam logic [3:0] CMD_LMR       = 4'hF;

   localparam logic [31:0] SYS_BYPASS_CKE = 32'h0000_0007;
   localparam logic [31:0] SYS_RUN        = 32'h0000_0004;

   localparam logic [3:0] LAST_STEP = 4'd8;

   typedef enum logic [2:0] {
      StIdle,
      StPowerup,
      StWrite,
      StWait,
      StDone,
      StError
   } state_e;

   typedef enum logic [1:0] {
      WaitPre,
      WaitDll,
      WaitRef,
      WaitNone
   } wait_e;

   function automatic logic [31:0] bypass_word(input logic [1:0]  ba,
                                               input logic [12:0] a,
                                               input logic [3:0]  cmd);
      return {13'd0, ba, a, cmd};
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hpdmc_initseq_rom.sv
// Step table of the JEDEC init sequence: maps a step index to the control-bus
// address, write data and the idle period that follows the write.
module hpdmc_initseq_rom
   import hpdmc_initseq_pkg::*;
#(
   parameter logic [2:0] MR_CL = 3'b010,
   parameter logic [2:0] MR_BL = 3'b011
) (
   input  logic [3:0]  step_i,
   output logic [31:0] adr_o,
   output logic [31:0] dat_o,
   output wait_e       wait_o
);

   logic [12:0] mr_a;

   always_comb begin
      // Mode register without DLL reset; A[8] is OR-ed in for the first MR write
      mr_a   = {4'd0, 1'b0, 1'b0, MR_CL, 1'b0, MR_BL};
      adr_o  = CSR_BYPASS;
      dat_o  = '0;
      wait_o = WaitNone;
      case (step_i)
         4'd0: begin
            adr_o  = CSR_SYSTEM;
            dat_o  = SYS_BYPASS_CKE;
            wait_o = WaitPre;
         end
         4'd1, 4'd4: begin
            dat_o  = bypass_word(2'b00, 13'h400, CMD_PRECHARGE);
            wait_o = WaitPre;
         end
         4'd2: begin
            dat_o  = bypass_word(2'b01, 13'h000, CMD_LMR);
            wait_o = WaitPre;
         end
         4'd3: begin
            dat_o  = bypass_word(2'b00, mr_a | 13'h100, CMD_LMR);
            wait_o = WaitDll;
         end
         4'd5, 4'd6: begin
            dat_o  = bypass_word(2'b00, 13'h000, CMD_REFRESH);
            wait_o = WaitRef;
         end
         4'd7: begin
            dat_o  = bypass_word(2'b00, mr_a, CMD_LMR);
            wait_o = WaitDll;
         end
         4'd8: begin
            adr_o  = CSR_SYSTEM;
            dat_o  = SYS_RUN;
            wait_o = WaitNone;
         end
         default: begin
            adr_o  = '0;
            dat_o  = '0;
            wait_o = WaitNone;
         end
      endcase
   end

endmodule

// File: rtl/hpdmc_initseq.sv
// SDRAM power-up sequencer: after a start pulse it waits the power-up time, then
// writes the init sequence through the hpdmc bypass CSR as a Wishbone master.
module hpdmc_initseq
   import hpdmc_initseq_pkg::*;
#(
   parameter int unsigned T_POWERUP   = 20000,
   parameter int unsigned T_DLL       = 200,
   parameter int unsigned T_PRE       = 2,
   parameter int unsigned T_REF       = 8,
   parameter logic [2:0]  MR_CL       = 3'b010,
   parameter logic [2:0]  MR_BL       = 3'b011,
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] wbc_adr_o,
   output logic [31:0] wbc_dat_o,
   output logic        wbc_cyc_o,
   output logic        wbc_stb_o,
   output logic        wbc_we_o,
   input  logic        wbc_ack_i
);

   localparam int unsigned CntMax = max_u(max_u(T_POWERUP, ACK_TIMEOUT),
                                          max_u(T_DLL, max_u(T_PRE, T_REF)));
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   state_e          state_q;
   logic [3:0]      step_q;
   logic [CntW-1:0] cnt_q;
   logic            stb_q;
   logic            busy_q;
   logic            done_q;
   logic            error_q;

   logic [31:0]     rom_adr;
   logic [31:0]     rom_dat;
   wait_e           rom_wait;
   logic [CntW-1:0] post_wait;

   hpdmc_initseq_rom #(
      .MR_CL (MR_CL),
      .MR_BL (MR_BL)
   ) u_rom (
      .step_i (step_q),
      .adr_o  (rom_adr),
      .dat_o  (rom_dat),
      .wait_o (rom_wait)
   );

   always_comb begin
      post_wait = '0;
      case (rom_wait)
         WaitPre: post_wait = CntW'(T_PRE);
         WaitDll: post_wait = CntW'(T_DLL);
         WaitRef: post_wait = CntW'(T_REF);
         default: post_wait = '0;
      endcase
   end

   // In WRITE the counter doubles as the ack timeout, preloaded on entry.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= StIdle;
         step_q  <= '0;
         cnt_q   <= '0;
         stb_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone, StError: begin
               if (start) begin
                  done_q  <= 1'b0;
                  error_q <= 1'b0;
                  busy_q  <= 1'b1;
                  step_q  <= '0;
                  cnt_q   <= CntW'(T_POWERUP);
                  state_q <= StPowerup;
               end
            end
            StPowerup: begin
               if (cnt_q == '0) begin
                  stb_q   <= 1'b1;
                  cnt_q   <= CntW'(ACK_TIMEOUT - 1);
                  state_q <= StWrite;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            StWrite: begin
               if (wbc_ack_i) begin
                  stb_q <= 1'b0;
                  if (step_q == LAST_STEP) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= StDone;
                  end else begin
                     cnt_q   <= post_wait;
                     state_q <= StWait;
                  end
               end else if (cnt_q == '0) begin
                  stb_q   <= 1'b0;
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StError;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            StWait: begin
               if (cnt_q == '0) begin
                  step_q  <= step_q + 4'd1;
                  stb_q   <= 1'b1;
                  cnt_q   <= CntW'(ACK_TIMEOUT - 1);
                  state_q <= StWrite;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign wbc_cyc_o = stb_q;
   assign wbc_stb_o = stb_q;
   assign wbc_we_o  = stb_q;
   assign wbc_adr_o = stb_q ? rom_adr : '0;
   assign wbc_dat_o = stb_q ? rom_dat : '0;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_hpdmc_initseq.sv
// Directed bench for hpdmc_initseq: a bus monitor records every write and its
// timing, and scenario tasks compare the log against hand-computed tables.
module tb_hpdmc_initseq;

   localparam int TPow = 100;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        start   = 1'b0;
   logic        ack     = 1'b0;
   logic        busy, done, error, cyc, stb, we;
   logic [31:0] adr, dat;

   int checks = 0;
   int errors = 0;
   int ccnt   = 0;

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) ccnt <= ccnt + 1;

   hpdmc_initseq #(
      .T_POWERUP (TPow)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .wbc_adr_o (adr),
      .wbc_dat_o (dat),
      .wbc_cyc_o (cyc),
      .wbc_stb_o (stb),
      .wbc_we_o  (we),
      .wbc_ack_i (ack)
   );

   logic [31:0] exp_adr [0:8] = '{32'h0, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h0};
   logic [31:0] exp_dat [0:8] = '{32'h7, 32'h400B, 32'h2000F, 32'h123F, 32'h400B,
                                  32'hD, 32'hD, 32'h23F, 32'h4};
   int          exp_gap [0:8] = '{0, 3, 3, 3, 201, 3, 9, 9, 201};

   // Monitor / responder state
   int          nw = 0;
   logic [31:0] wr_adr [0:15];
   logic [31:0] wr_dat [0:15];
   int          wr_rise [0:15];
   int          wr_gap [0:15];
   int          hi_len [0:15];
   int          dly [0:15];
   int          fall_c = 0;
   int          done_c = -1;
   int          unstable = 0;
   int          we_bad = 0;
   int          idle_bad = 0;
   bit          ack_en = 1'b1;
   logic        stb_prev = 1'b0;
   logic        done_prev = 1'b0;

   initial begin
      forever begin
         @(negedge sys_clk);
         if (stb && !stb_prev) begin
            if (nw < 16) begin
               wr_adr[nw]  = adr;
               wr_dat[nw]  = dat;
               wr_rise[nw] = ccnt;
               wr_gap[nw]  = ccnt - fall_c;
               hi_len[nw]  = 0;
            end
            nw++;
         end
         if (stb) begin
            if (nw >= 1 && nw <= 16) begin
               hi_len[nw-1]++;
               if (adr !== wr_adr[nw-1] || dat !== wr_dat[nw-1]) unstable++;
            end
            if (cyc !== 1'b1 || we !== 1'b1) we_bad++;
         end else begin
            if (stb_prev) fall_c = ccnt;
            if (cyc !== 1'b0 || we !== 1'b0 || adr !== 32'h0 || dat !== 32'h0) idle_bad++;
         end
         if (done && !done_prev) done_c = ccnt;
         stb_prev  = stb;
         done_prev = done;
         ack = stb && ack_en && nw >= 1 && nw <= 16 && (hi_len[nw-1] > dly[nw-1]);
      end
   end

   task automatic clear_mon();
      nw       = 0;
      unstable = 0;
      we_bad   = 0;
      idle_bad = 0;
      done_c   = -1;
      for (int i = 0; i < 16; i++) begin
         dly[i]    = 0;
         hi_len[i] = 0;
      end
   endtask

   // Called at posedge+1; returns the cycle stamp of the edge that sampled start.
   task automatic pulse_start(output int s);
      start = 1'b1;
      @(posedge sys_clk);
      #1;
      start = 1'b0;
      s = ccnt;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      checks++;
      if ({busy, done, error} !== 3'b000) begin
         errors++; $display("FAIL reset_status: got %b expected 000", {busy, done, error});
      end
      checks++;
      if ({cyc, stb, we} !== 3'b000) begin
         errors++; $display("FAIL reset_bus: got %b expected 000", {cyc, stb, we});
      end
      checks++;
      if (adr !== 32'h0 || dat !== 32'h0) begin
         errors++; $display("FAIL reset_adr_dat: got %h/%h expected 0/0", adr, dat);
      end
      sys_rst = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      checks++;
      if ({busy, stb} !== 2'b00) begin
         errors++; $display("FAIL reset_idle: got %b expected 00", {busy, stb});
      end
   endtask

   task automatic test_powerup();
      int s;
      clear_mon();
      pulse_start(s);
      for (int i = 0; i < 3000 && !done; i++) begin
         @(posedge sys_clk);
         #1;
      end
      repeat (2) @(posedge sys_clk);
      #1;
      checks++;
      if ({done, busy, error} !== 3'b100) begin
         errors++; $display("FAIL powerup_status: got %b expected 100", {done, busy, error});
      end
      checks++;
      if (nw !== 9) begin
         errors++; $display("FAIL powerup_count: got %0d expected 9", nw);
      end
      checks++;
      if (wr_rise[0] - s !== TPow + 1) begin
         errors++; $display("FAIL powerup_first_stb: got %0d expected %0d", wr_rise[0] - s, TPow + 1);
      end
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (wr_adr[k] !== exp_adr[k] || wr_dat[k] !== exp_dat[k]) begin
            errors++;
            $display("FAIL powerup_write[%0d]: got %h=%h expected %h=%h",
                     k, wr_adr[k], wr_dat[k], exp_adr[k], exp_dat[k]);
         end
         checks++;
         if (hi_len[k] !== 1) begin
            errors++; $display("FAIL powerup_stb_len[%0d]: got %0d expected 1", k, hi_len[k]);
         end
         if (k > 0) begin
            checks++;
            if (wr_gap[k] !== exp_gap[k]) begin
               errors++; $display("FAIL powerup_gap[%0d]: got %0d expected %0d", k, wr_gap[k], exp_gap[k]);
            end
         end
      end
      checks++;
      if (done_c !== fall_c) begin
         errors++; $display("FAIL powerup_done_timing: got %0d expected %0d", done_c, fall_c);
      end
      checks++;
      if (unstable !== 0 || we_bad !== 0 || idle_bad !== 0) begin
         errors++;
         $display("FAIL powerup_bus_rules: got %0d/%0d/%0d expected 0/0/0", unstable, we_bad, idle_bad);
      end
   endtask

   task automatic test_ack_delay();
      int s;
      clear_mon();
      dly[3] = 3;
      pulse_start(s);
      for (int i = 0; i < 3000 && !done; i++) begin
         @(posedge sys_clk);
         #1;
      end
      repeat (2) @(posedge sys_clk);
      #1;
      checks++;
      if (nw !== 9 || done !== 1'b1) begin
         errors++; $display("FAIL delay_complete: got %0d/%b expected 9/1", nw, done);
      end
      checks++;
      if (hi_len[3] !== 4) begin
         errors++; $display("FAIL delay_stb_len: got %0d expected 4", hi_len[3]);
      end
      checks++;
      if (wr_adr[3] !== 32'h4 || wr_dat[3] !== 32'h123F || unstable !== 0) begin
         errors++;
         $display("FAIL delay_stable: got %h=%h unstable %0d expected 4=123f unstable 0",
                  wr_adr[3], wr_dat[3], unstable);
      end
      checks++;
      if (wr_gap[4] !== 201) begin
         errors++; $display("FAIL delay_dll_gap: got %0d expected 201", wr_gap[4]);
      end
   endtask

   task automatic test_back_to_back();
      int s;
      clear_mon();
      pulse_start(s);
      for (int i = 0; i < 3000 && nw < 5; i++) begin
         @(posedge sys_clk);
         #1;
      end
      start = 1'b1;
      @(posedge sys_clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(posedge sys_clk);
         #1;
      end
      repeat (2) @(posedge sys_clk);
      #1;
      checks++;
      if (nw !== 9 || done !== 1'b1) begin
         errors++; $display("FAIL b2b_complete: got %0d/%b expected 9/1", nw, done);
      end
      checks++;
      if (wr_rise[0] - s !== TPow + 1) begin
         errors++; $display("FAIL b2b_first_stb: got %0d expected %0d", wr_rise[0] - s, TPow + 1);
      end
      for (int k = 1; k < 9; k++) begin
         checks++;
         if (wr_dat[k] !== exp_dat[k] || wr_gap[k] !== exp_gap[k]) begin
            errors++;
            $display("FAIL b2b_write[%0d]: got %h gap %0d expected %h gap %0d",
                     k, wr_dat[k], wr_gap[k], exp_dat[k], exp_gap[k]);
         end
      end
   endtask

   task automatic test_timeout();
      int s;
      clear_mon();
      ack_en = 1'b0;
      pulse_start(s);
      for (int i = 0; i < 1000 && !error; i++) begin
         @(posedge sys_clk);
         #1;
      end
      repeat (2) @(posedge sys_clk);
      #1;
      checks++;
      if ({error, busy, done, cyc, stb} !== 5'b10000) begin
         errors++;
         $display("FAIL timeout_status: got %b expected 10000", {error, busy, done, cyc, stb});
      end
      checks++;
      if (nw !== 1 || hi_len[0] !== 64) begin
         errors++; $display("FAIL timeout_len: got %0d writes %0d cycles expected 1/64", nw, hi_len[0]);
      end
      ack_en = 1'b1;
      clear_mon();
      pulse_start(s);
      for (int i = 0; i < 3000 && !done; i++) begin
         @(posedge sys_clk);
         #1;
      end
      repeat (2) @(posedge sys_clk);
      #1;
      checks++;
      if (wr_rise[0] - s !== TPow + 1) begin
         errors++; $display("FAIL timeout_rerun_wait: got %0d expected %0d", wr_rise[0] - s, TPow + 1);
      end
      checks++;
      if (nw !== 9 || wr_dat[0] !== 32'h7 || {done, error} !== 2'b10) begin
         errors++;
         $display("FAIL timeout_rerun: got %0d/%h/%b expected 9/7/10", nw, wr_dat[0], {done, error});
      end
   endtask

   task automatic test_reset_mid();
      int s;
      clear_mon();
      dly[5] = 10;
      pulse_start(s);
      for (int i = 0; i < 3000 && !(nw >= 6 && stb); i++) begin
         @(posedge sys_clk);
         #1;
      end
      checks++;
      if (stb !== 1'b1 || dat !== 32'hD) begin
         errors++; $display("FAIL rstmid_reach: got %b/%h expected 1/d", stb, dat);
      end
      sys_rst = 1'b1;
      #1;
      checks++;
      if ({cyc, stb, we, busy} !== 4'b0000) begin
         errors++; $display("FAIL rstmid_async: got %b expected 0000", {cyc, stb, we, busy});
      end
      sys_rst = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      clear_mon();
      pulse_start(s);
      for (int i = 0; i < 3000 && !done; i++) begin
         @(posedge sys_clk);
         #1;
      end
      repeat (2) @(posedge sys_clk);
      #1;
      checks++;
      if (wr_adr[0] !== 32'h0 || wr_dat[0] !== 32'h7) begin
         errors++; $display("FAIL rstmid_restart: got %h=%h expected 0=7", wr_adr[0], wr_dat[0]);
      end
      checks++;
      if (nw !== 9 || done !== 1'b1 || wr_rise[0] - s !== TPow + 1) begin
         errors++;
         $display("FAIL rstmid_complete: got %0d/%b/%0d expected 9/1/%0d",
                  nw, done, wr_rise[0] - s, TPow + 1);
      end
   endtask

   initial begin
      test_reset();
      test_powerup();
      test_ack_delay();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
